hazard_sequencer: RTL

- Central stall/flush controller for the five-stage pipeline. Produces per-register stall and flush for i2d, d2e, e2m and m2w, plus the PC-register stall and the PC redirect.
- Arbitrates between i-cache miss, d-cache miss, load-use and branch-mispredict hazards.
- Holds a mispredict redirect that arrives during an i-cache fill and applies it when the fill ends.
- Keeps saturating hazard performance counters.

---
 rtl/mips_core_pkg.sv | 16 +
 rtl/sat_counter.sv | 38 +++
 rtl/hazard_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared types for the pipeline hazard sequencer
package mips_core_pkg;

    typedef enum logic {
        RUN        = 1'b0,
        WAIT_IFILL = 1'b1
    } hazard_state_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctl_t;

    localparam stage_ctl_t STAGE_IDLE = '{stall: 1'b0, flush: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int COUNTER_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [COUNTER_W-1:0] count
);

    localparam logic [COUNTER_W-1:0] ONE = {{(COUNTER_W-1){1'b0}}, 1'b1};

    logic [COUNTER_W-1:0] count_q;
    logic [COUNTER_W-1:0] count_d;

    // Clear wins over increment; stop at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {COUNTER_W{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline stall/flush controller with deferred redirect
module hazard_sequencer
    import mips_core_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int COUNTER_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ic_miss,
    input  logic                 dc_miss,
    input  logic                 load_use,
    input  logic                 mispredict,
    input  logic [ADDR_W-1:0]    mispredict_target,
    input  logic                 perf_clear,
    output logic                 pc_stall,
    output logic                 i2d_stall,
    output logic                 i2d_flush,
    output logic                 d2e_stall,
    output logic                 d2e_flush,
    output logic                 e2m_stall,
    output logic                 e2m_flush,
    output logic                 m2w_stall,
    output logic                 m2w_flush,
    output logic                 redirect_valid,
    output logic [ADDR_W-1:0]    redirect_pc,
    output logic                 redirect_pending,
    output logic [COUNTER_W-1:0] cnt_ic_stall,
    output logic [COUNTER_W-1:0] cnt_dc_stall,
    output logic [COUNTER_W-1:0] cnt_load_use,
    output logic [COUNTER_W-1:0] cnt_mispredict
);

    hazard_state_t     state_q, state_d;
    logic [ADDR_W-1:0] saved_q, saved_d;

    stage_ctl_t i2d_ctl, d2e_ctl, e2m_ctl, m2w_ctl;
    logic       pc_hold;
    logic       redir;
    logic [ADDR_W-1:0] redir_pc;
    logic       load_use_taken;
    logic       mispredict_taken;

    // Priority decode of hazards into per-register controls and next state.
    always_comb begin
        i2d_ctl          = STAGE_IDLE;
        d2e_ctl          = STAGE_IDLE;
        e2m_ctl          = STAGE_IDLE;
        m2w_ctl          = STAGE_IDLE;
        pc_hold          = 1'b0;
        redir            = 1'b0;
        redir_pc         = mispredict_target;
        state_d          = state_q;
        saved_d          = saved_q;
        load_use_taken   = 1'b0;
        mispredict_taken = 1'b0;

        if (dc_miss) begin
            // Freeze everything upstream of MEM; a pending mispredict in EX
            // stays asserted and is taken once the miss resolves.
            pc_hold       = 1'b1;
            i2d_ctl.stall = 1'b1;
            d2e_ctl.stall = 1'b1;
            e2m_ctl.stall = 1'b1;
            m2w_ctl.flush = 1'b1;
        end else if (state_q == RUN && mispredict && ic_miss) begin
            // Fetch cannot accept a new PC mid-fill; park the target.
            pc_hold          = 1'b1;
            i2d_ctl.flush    = 1'b1;
            d2e_ctl.flush    = 1'b1;
            saved_d          = mispredict_target;
            state_d          = WAIT_IFILL;
            mispredict_taken = 1'b1;
        end else if (state_q == RUN && mispredict) begin
            // D holds a wrong-path instruction, so any load_use is moot.
            redir            = 1'b1;
            i2d_ctl.flush    = 1'b1;
            d2e_ctl.flush    = 1'b1;
            mispredict_taken = 1'b1;
        end else if (state_q == WAIT_IFILL && ic_miss) begin
            pc_hold       = 1'b1;
            i2d_ctl.flush = 1'b1;
        end else if (state_q == WAIT_IFILL) begin
            redir         = 1'b1;
            redir_pc      = saved_q;
            i2d_ctl.flush = 1'b1;
            state_d       = RUN;
        end else if (load_use) begin
            // Hold D, bubble EX; i2d stall takes precedence over the
            // i-cache miss bubble.
            pc_hold        = 1'b1;
            i2d_ctl.stall  = 1'b1;
            d2e_ctl.flush  = 1'b1;
            load_use_taken = 1'b1;
        end else if (ic_miss) begin
            pc_hold       = 1'b1;
            i2d_ctl.flush = 1'b1;
        end
    end

    // FSM state and parked redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            saved_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
        end
    end

    assign pc_stall         = pc_hold;
    assign i2d_stall        = i2d_ctl.stall;
    assign i2d_flush        = i2d_ctl.flush & ~i2d_ctl.stall;
    assign d2e_stall        = d2e_ctl.stall;
    assign d2e_flush        = d2e_ctl.flush & ~d2e_ctl.stall;
    assign e2m_stall        = e2m_ctl.stall;
    assign e2m_flush        = e2m_ctl.flush & ~e2m_ctl.stall;
    assign m2w_stall        = m2w_ctl.stall;
    assign m2w_flush        = m2w_ctl.flush & ~m2w_ctl.stall;
    assign redirect_valid   = redir;
    assign redirect_pc      = redir_pc;
    assign redirect_pending = (state_q == WAIT_IFILL);

    sat_counter #(.COUNTER_W(COUNTER_W)) u_cnt_ic (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ic_miss),
        .clr   (perf_clear),
        .count (cnt_ic_stall)
    );

    sat_counter #(.COUNTER_W(COUNTER_W)) u_cnt_dc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dc_miss),
        .clr   (perf_clear),
        .count (cnt_dc_stall)
    );

    sat_counter #(.COUNTER_W(COUNTER_W)) u_cnt_lu (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_use_taken),
        .clr   (perf_clear),
        .count (cnt_load_use)
    );

    sat_counter #(.COUNTER_W(COUNTER_W)) u_cnt_mp (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mispredict_taken),
        .clr   (perf_clear),
        .count (cnt_mispredict)
    );

endmodule
